// File: rtl/serie_paralelo_rx_if.sv
// Serial receive bundle: bitstream in, aligned bytes and link status out.
// The receiver uses the slave modport; the master modport is the line/consumer side.
interface serie_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_tick;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  byte_tick
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output byte_tick
    );
endinterface

// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: comma alignment search, sync qualification, byte output.
// Latency: outputs update on the edge sampling a byte's LSB; no backpressure, one bit per clk_8f.
module serie_paralelo_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input logic              clk_8f,
    input logic              reset,
    serie_paralelo_rx_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] SYNC_TARGET = 3'(SYNC_COUNT);

    state_t     state_q, state_d;
    logic [7:0] shreg_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q;
    logic       tick_q, tick_d;

    logic [7:0] cand;
    logic       boundary;
    logic       is_comma;

    // Candidate includes the bit being sampled so a match is seen on the LSB edge itself.
    assign cand     = {shreg_q[6:0], bus.data_in};
    assign boundary = (bit_cnt_q == 3'd7);
    assign is_comma = (cand == COMMA);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        tick_d    = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (is_comma) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 3'd1;
                    tick_d    = 1'b1;
                    state_d   = (SYNC_COUNT == 1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    tick_d = 1'b1;
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 3'd1;
                        if (bc_cnt_q + 3'd1 == SYNC_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        bc_cnt_d = 3'd0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    tick_d = 1'b1;
                    if (is_comma) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = cand;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            shreg_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= cand;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= (state_d == ACTIVE);
            tick_q    <= tick_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;
    assign bus.byte_tick = tick_q;

endmodule
